stream_decrypt: RTL and testbench



---
 rtl/cipher_pkg.sv | 29 ++
 rtl/byte_fifo2.sv | 52 +++++
 rtl/stream_decrypt.sv | 88 ++++++++
 tb/tb_stream_decrypt.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Cipher primitives shared by the serial encryptor and the stream decryptor.
// Both ends derive the keystream from the same key_at().
package cipher_pkg;
  typedef logic [7:0] byte_t;

  typedef enum logic {
    IDX_IDLE,
    IDX_RUN
  } idx_state_t;

  localparam int    DEF_MSG_LEN  = 9;
  localparam byte_t DEF_KEY      = 8'h5A;
  localparam byte_t DEF_KEY_STEP = 8'h01;

  // Position-dependent keystream; the product wraps to 8 bits before the add.
  function automatic byte_t key_at(input byte_t idx, input byte_t key, input byte_t step);
    byte_t prod;
    prod = byte_t'(idx * step);
    return key + prod;
  endfunction

  function automatic byte_t enc_byte(input byte_t p, input byte_t k);
    return p + k;
  endfunction

  function automatic byte_t dec_byte(input byte_t c, input byte_t k);
    return c - k;
  endfunction
endpackage

// File: rtl/byte_fifo2.sv
// Two-entry {data, last} FIFO; entry 0 is always the head, so head outputs
// come straight from a register and hold while the consumer stalls.
module byte_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_last,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       head_last,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);
  logic [7:0] data0, data1;
  logic       last0, last1;
  logic       do_push, do_pop;

  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = data0;
  assign head_last = last0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      data0 <= 8'h00;
      data1 <= 8'h00;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      if (do_pop && count == 2'd2) begin
        data0 <= data1;
        last0 <= last1;
      end
      // A push lands in the head slot when the head is empty or leaving this cycle.
      if (do_push) begin
        if (count == 2'd0 || do_pop) begin
          data0 <= push_data;
          last0 <= push_last;
        end else begin
          data1 <= push_data;
          last1 <= push_last;
        end
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/stream_decrypt.sv
// Byte-serial stream decryptor: strips the position keystream, checks message
// framing against MSG_LEN and hands plaintext out through a 2-entry buffer.
module stream_decrypt
  import cipher_pkg::*;
#(
  parameter int         MSG_LEN  = DEF_MSG_LEN,
  parameter logic [7:0] KEY      = DEF_KEY,
  parameter logic [7:0] KEY_STEP = DEF_KEY_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_err,
  output logic       msg_done
);
  localparam byte_t LAST_IDX = byte_t'(MSG_LEN - 1);

  idx_state_t state, next_state;
  byte_t      idx, next_idx, cur_idx, plain_p0;
  logic       accept, pop, last_p0, at_end, err_d, done_d;
  logic       fifo_full, fifo_empty;
  logic [1:0] fifo_count;

  assign in_ready  = (fifo_count < 2'd2);
  assign accept    = in_valid && !fifo_full;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_ready && !fifo_empty;

  assign cur_idx  = (state == IDX_IDLE) ? '0 : idx;
  assign at_end   = (cur_idx == LAST_IDX);
  assign plain_p0 = dec_byte(in_data, key_at(cur_idx, KEY, KEY_STEP));
  assign last_p0  = at_end || in_last;

  always_comb begin
    next_state = state;
    next_idx   = idx;
    err_d      = 1'b0;
    done_d     = 1'b0;
    if (accept) begin
      if (last_p0) begin
        // Any end of frame, good or bad, restarts the keystream at position 0.
        next_state = IDX_IDLE;
        next_idx   = '0;
        done_d     = in_last && at_end;
        err_d      = !(in_last && at_end);
      end else begin
        next_state = IDX_RUN;
        next_idx   = cur_idx + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDX_IDLE;
      idx       <= '0;
      frame_err <= 1'b0;
      msg_done  <= 1'b0;
    end else begin
      state     <= next_state;
      idx       <= next_idx;
      frame_err <= err_d;
      msg_done  <= done_d;
    end
  end

  // Stage boundary: decrypted byte is registered into the output buffer.
  byte_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (plain_p0),
    .push_last (last_p0),
    .pop       (pop),
    .head_data (out_data),
    .head_last (out_last),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_stream_decrypt.sv
// Bench for stream_decrypt: message tables, directed corner sequences and a
// randomized run, all checked against a queue-based model of the cipher rules.
module tb_stream_decrypt;
  localparam int         MSG_LEN = 9;
  localparam logic [7:0] KEY     = 8'h5A;
  localparam logic [7:0] STEP    = 8'h01;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid, out_last, frame_err, msg_done;
  logic [7:0] out_data;

  stream_decrypt #(.MSG_LEN(MSG_LEN), .KEY(KEY), .KEY_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       last;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;
  vec_t tab[9];

  int total = 0, bad = 0;

  // Reference model: buffered plaintext queue plus message position.
  logic [7:0] mq_data[$];
  logic       mq_last[$];
  int         m_idx  = 0;
  logic       m_err  = 1'b0, m_done = 1'b0;

  logic [7:0] got[$];
  logic       got_last[$];
  int         err_cnt = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq_data.delete();
    mq_last.delete();
    m_idx  = 0;
    m_err  = 1'b0;
    m_done = 1'b0;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic       acc, pp, is_end;
    logic [7:0] k, p;
    @(negedge clk);
    check("in_ready", in_ready, mq_data.size() < 2);
    check("out_valid", out_valid, mq_data.size() != 0);
    if (mq_data.size() != 0) begin
      check("out_data", out_data, mq_data[0]);
      check("out_last", out_last, mq_last[0]);
    end
    check("frame_err", frame_err, m_err);
    check("msg_done", msg_done, m_done);
    if (frame_err) err_cnt++;
    if (msg_done)  done_cnt++;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    acc = v && (mq_data.size() < 2);
    pp  = r && (mq_data.size() != 0);
    if (pp) begin
      got.push_back(out_data);
      got_last.push_back(out_last);
    end
    @(posedge clk);
    m_err  = 1'b0;
    m_done = 1'b0;
    if (pp) begin
      void'(mq_data.pop_front());
      void'(mq_last.pop_front());
    end
    if (acc) begin
      k      = 8'((int'(KEY) + m_idx * int'(STEP)) % 256);
      p      = 8'((int'(d) - int'(k) + 256) % 256);
      is_end = (m_idx == MSG_LEN - 1);
      mq_data.push_back(p);
      mq_last.push_back(is_end || l);
      m_done = l && is_end;
      m_err  = (l != is_end);
      m_idx  = (is_end || l) ? 0 : m_idx + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic clear_obs();
    got.delete(); got_last.delete(); err_cnt = 0; done_cnt = 0;
  endtask

  // Finish the current message from position `from` using the nominal table.
  task automatic finish_msg(input int from);
    for (int i = from; i < 9; i++) cycle(1'b1, tab[i].din, tab[i].last, 1'b1);
    idle(3);
  endtask

  initial begin
    tab[0] = '{8'h9B, 1'b0, 8'h41, 1'b0};
    tab[1] = '{8'h9C, 1'b0, 8'h41, 1'b0};
    tab[2] = '{8'h9D, 1'b0, 8'h41, 1'b0};
    tab[3] = '{8'h9F, 1'b0, 8'h42, 1'b0};
    tab[4] = '{8'hA0, 1'b0, 8'h42, 1'b0};
    tab[5] = '{8'hA1, 1'b0, 8'h42, 1'b0};
    tab[6] = '{8'hA3, 1'b0, 8'h43, 1'b0};
    tab[7] = '{8'hA4, 1'b0, 8'h43, 1'b0};
    tab[8] = '{8'hA5, 1'b1, 8'h43, 1'b1};

    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_msg_done", msg_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal message
    clear_obs();
    for (int i = 0; i < 9; i++) cycle(1'b1, tab[i].din, tab[i].last, 1'b1);
    idle(3);
    check("nom_count", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      check("nom_data", got[i], tab[i].exp_data);
      check("nom_last", got_last[i], tab[i].exp_last);
    end
    check("nom_done", done_cnt, 1);
    check("nom_err", err_cnt, 0);

    // Wrap-around arithmetic at position 0 (each a one-byte short frame)
    clear_obs();
    cycle(1'b1, 8'h10, 1'b1, 1'b1);
    cycle(1'b1, 8'h5A, 1'b1, 1'b1);
    idle(3);
    check("wrap_count", got.size(), 2);
    if (got.size() == 2) begin
      check("wrap_b6", got[0], 8'hB6);
      check("wrap_00", got[1], 8'h00);
    end

    // Back-pressure: third offer stalls, order preserved
    clear_obs();
    cycle(1'b1, 8'h9B, 1'b0, 1'b0);
    cycle(1'b1, 8'h9C, 1'b0, 1'b0);
    cycle(1'b1, 8'h9D, 1'b0, 1'b0);
    check("bp_ready_low", in_ready, 0);
    check("bp_hold", out_data, 8'h41);
    cycle(1'b1, 8'h9D, 1'b0, 1'b1);
    cycle(1'b1, 8'h9D, 1'b0, 1'b1);
    check("bp_ready_back", in_ready, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);
    check("bp_count", got.size(), 3);
    for (int i = 0; i < got.size(); i++) check("bp_order", got[i], 8'h41);
    finish_msg(3);

    // Short frame: in_last on 4th byte
    clear_obs();
    for (int i = 0; i < 3; i++) cycle(1'b1, tab[i].din, 1'b0, 1'b1);
    cycle(1'b1, 8'h9F, 1'b1, 1'b1);
    idle(2);
    cycle(1'b1, 8'h9B, 1'b0, 1'b1);
    idle(2);
    check("short_count", got.size(), 5);
    if (got.size() == 5) begin
      check("short_4th", got[3], 8'h42);
      check("short_last", got_last[3], 1);
      check("short_next", got[4], 8'h41);
    end
    check("short_err", err_cnt, 1);
    finish_msg(1);

    // Missing last: 9 bytes without in_last
    clear_obs();
    for (int i = 0; i < 9; i++) cycle(1'b1, tab[i].din, 1'b0, 1'b1);
    idle(2);
    cycle(1'b1, 8'h9B, 1'b0, 1'b1);
    idle(2);
    check("miss_count", got.size(), 10);
    if (got.size() == 10) begin
      check("miss_last", got_last[8], 1);
      check("miss_next", got[9], 8'h41);
    end
    check("miss_err", err_cnt, 1);
    check("miss_done", done_cnt, 0);
    finish_msg(1);

    // Reset mid-message with two bytes buffered
    for (int i = 0; i < 4; i++) cycle(1'b1, tab[i].din, 1'b0, 1'b1);
    cycle(1'b1, tab[4].din, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_data", out_data, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    cycle(1'b1, 8'h9B, 1'b0, 1'b1);
    idle(2);
    check("rst_next_count", got.size(), 1);
    if (got.size() == 1) check("rst_next", got[0], 8'h41);
    finish_msg(1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) != 0));
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
